// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the port arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
        output i_rdata, i_ack, d_rdata, d_ack, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one slow memory port between the fetch and data sides, with
// per-transaction sequencing, a forced idle gap afterwards and a completion watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_ACCESS  = 2'd1;
    localparam logic [1:0]  ST_RESPOND = 2'd2;
    localparam logic [1:0]  ST_GAP     = 2'd3;
    localparam logic [7:0]  TIMEOUT_C  = TIMEOUT[7:0];
    localparam logic [3:0]  GAP_C      = GAP_CYCLES[3:0];
    localparam logic [31:0] ABORT_WORD = 32'hDEADBEEF;
    localparam logic        SIDE_I     = 1'b0;
    localparam logic        SIDE_D     = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        op_we_q, op_we_d;
    logic        op_side_q, op_side_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [7:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        grant_any_s;
    logic        grant_side_s;
    logic        access_done_s;
    logic        access_abort_s;
    logic [31:0] resp_word_s;

    // The first ACCESS cycle ignores mem_done so a level left over from the previous access cannot complete this one.
    assign access_done_s  = (state_q == ST_ACCESS) && (acc_cnt_q != 8'd1) && bus.mem_done;
    assign access_abort_s = (state_q == ST_ACCESS) && !access_done_s && (acc_cnt_q == TIMEOUT_C);
    assign resp_word_s    = access_done_s ? bus.mem_rdata : ABORT_WORD;

    // Round-robin pick: on a tie the side that did not win last time is granted.
    always_comb begin
        grant_any_s = bus.i_req | bus.d_req;
        if (bus.i_req && bus.d_req) begin
            grant_side_s = ~last_grant_q;
        end else if (bus.d_req) begin
            grant_side_s = SIDE_D;
        end else begin
            grant_side_s = SIDE_I;
        end
    end

    // Transaction sequencer next-state logic.
    always_comb begin
        state_d       = state_q;
        op_we_d       = op_we_q;
        op_side_d     = op_side_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        acc_cnt_d     = acc_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    op_side_d    = grant_side_s;
                    last_grant_d = grant_side_s;
                    op_we_d      = (grant_side_s == SIDE_D) ? bus.d_we : 1'b0;
                    mem_addr_d   = (grant_side_s == SIDE_D) ? bus.d_addr : bus.i_addr;
                    mem_wdata_d  = (grant_side_s == SIDE_D) ? bus.d_wdata : 32'h0000_0000;
                    acc_cnt_d    = 8'd1;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (access_done_s || access_abort_s) begin
                    state_d   = ST_RESPOND;
                    acc_cnt_d = 8'd0;
                    if (access_abort_s) begin
                        timeout_err_d = 1'b1;
                    end else begin
                        timeout_err_d = timeout_err_q;
                    end
                    if (op_side_q == SIDE_D) begin
                        d_ack_d = 1'b1;
                        // A write returns no data; the read-data register keeps its last value.
                        if (!op_we_q) begin
                            d_rdata_d = resp_word_s;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_word_s;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + 8'd1;
                end
            end
            ST_RESPOND: begin
                gap_cnt_d = 4'd1;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q >= GAP_C) begin
                    gap_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; an in-flight transaction is simply dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            op_we_q       <= 1'b0;
            op_side_q     <= SIDE_I;
            last_grant_q  <= SIDE_I;
            mem_addr_q    <= 32'h0000_0000;
            mem_wdata_q   <= 32'h0000_0000;
            i_rdata_q     <= 32'h0000_0000;
            d_rdata_q     <= 32'h0000_0000;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            acc_cnt_q     <= 8'd0;
            gap_cnt_q     <= 4'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_we_q       <= op_we_d;
            op_side_q     <= op_side_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            acc_cnt_q     <= acc_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.mem_re    = (state_q == ST_ACCESS) & ~op_we_q;
    assign bus.mem_we    = (state_q == ST_ACCESS) & op_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_err   = timeout_err_q;
endmodule
